// File: rtl/hsid_x_obi_rd_fetch_if.sv
// OBI read channel plus pixel stream between the fetch engine and its neighbours.
// The master modport is the fetch engine's view of both channels.
interface hsid_x_obi_rd_fetch_if #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 16
);
  logic                    req;
  logic [WORD_WIDTH-1:0]   addr;
  logic                    we;
  logic [WORD_WIDTH/8-1:0] be;
  logic [WORD_WIDTH-1:0]   wdata;
  logic                    gnt;
  logic                    rvalid;
  logic [WORD_WIDTH-1:0]   rdata;

  logic                    pix_valid;
  logic [DATA_WIDTH-1:0]   pix_data;
  logic                    pix_last;
  logic                    pix_ready;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata,
    output pix_valid, pix_data, pix_last,
    input  pix_ready
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata,
    input  pix_valid, pix_data, pix_last,
    output pix_ready
  );
endinterface

// File: rtl/hsid_x_obi_rd_fetch.sv
// OBI read initiator: fetches num_words consecutive words and streams each one as two pixels
// (low half first). A credit limit keeps in-flight plus buffered words within the FIFO.
module hsid_x_obi_rd_fetch #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  num_words,
  output logic                  busy,
  output logic                  done,
  hsid_x_obi_rd_fetch_if.master bus
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  num_q, num_d;
  logic [LEN_WIDTH-1:0]  issued_q, issued_d;
  logic [LEN_WIDTH-1:0]  popped_q, popped_d;
  logic [CntW-1:0]       out_q, out_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [PtrW-1:0]       wptr_q, rptr_q;
  logic [WORD_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic                  half_q, half_d;
  logic                  req_q, req_d;

  logic                  accept, rsp, push, pop, pix_fire, last_word, fifo_nonempty;
  logic [CntW:0]         credit_used;
  logic [WORD_WIDTH-1:0] head;

  assign accept        = req_q & bus.gnt;
  // A response with nothing outstanding is a leftover from before reset.
  assign rsp           = bus.rvalid & (out_q != '0);
  assign push          = rsp;
  assign fifo_nonempty = (cnt_q != '0);
  assign pix_fire      = fifo_nonempty & bus.pix_ready;
  assign pop           = pix_fire & half_q;
  assign last_word     = (popped_q == num_q - LEN_WIDTH'(1));

  assign out_d       = out_q + CntW'(accept) - CntW'(rsp);
  assign cnt_d       = cnt_q + CntW'(push) - CntW'(pop);
  assign credit_used = {1'b0, out_d} + {1'b0, cnt_d};

  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    addr_d   = accept ? addr_q + WORD_WIDTH'(4) : addr_q;
    issued_d = issued_q + LEN_WIDTH'(accept);
    popped_d = popped_q + LEN_WIDTH'(pop);
    half_d   = pix_fire ? ~half_q : half_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (num_words == '0) begin
            state_d = StDone;
          end else begin
            state_d  = StFetch;
            num_d    = num_words;
            addr_d   = {base_addr[WORD_WIDTH-1:2], 2'b00};
            issued_d = '0;
            popped_d = '0;
            half_d   = 1'b0;
          end
        end
      end
      StFetch: begin
        if (accept && (issued_d == num_q)) state_d = StDrain;
      end
      StDrain: begin
        if (pop && last_word && (out_d == '0) && (cnt_d == '0)) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Registered request built from next-state counts: once raised it can only drop on a grant,
  // since in-flight plus buffered words never grow without one.
  assign req_d = (state_d == StFetch) && (issued_d < num_d) &&
                 (credit_used < (CntW + 1)'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      num_q    <= '0;
      issued_q <= '0;
      popped_q <= '0;
      out_q    <= '0;
      cnt_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      half_q   <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      num_q    <= num_d;
      issued_q <= issued_d;
      popped_q <= popped_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
      half_q   <= half_d;
      req_q    <= req_d;
      if (push) wptr_q <= (wptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : wptr_q + PtrW'(1);
      if (pop)  rptr_q <= (rptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : rptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus.rdata;
  end

  assign head = mem_q[rptr_q];

  assign bus.req       = req_q;
  assign bus.addr      = addr_q;
  assign bus.we        = 1'b0;
  assign bus.be        = '1;
  assign bus.wdata     = '0;
  assign bus.pix_valid = fifo_nonempty;
  assign bus.pix_data  = !fifo_nonempty ? '0 :
                         half_q ? head[WORD_WIDTH-1:DATA_WIDTH] : head[DATA_WIDTH-1:0];
  assign bus.pix_last  = fifo_nonempty & half_q & last_word;

  assign busy = (state_q == StFetch) || (state_q == StDrain);
  assign done = (state_q == StDone);

  fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (cnt_q == CntW'(FIFO_DEPTH))));

endmodule
